// File: rtl/clint_arb.sv
// clint_arb: round-robin arbiter and access sequencer for the core-local
// timer register port. Two requesters share one timer port; each accepted
// request becomes one ACCESS cycle on the timer followed by one RESP cycle
// back to the owner. One transaction is in flight at a time.
module clint_arb #(
  parameter logic [63:0] ADDR_MTIME    = 64'h0000_0000_0200_BFF8,
  parameter logic [63:0] ADDR_MTIMECMP = 64'h0000_0000_0200_4000
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic        m0_req_wen,
  input  logic [63:0] m0_req_addr,
  input  logic [63:0] m0_req_wdata,
  output logic        m0_resp_valid,
  output logic        m0_resp_err,
  output logic [63:0] m0_resp_rdata,

  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic        m1_req_wen,
  input  logic [63:0] m1_req_addr,
  input  logic [63:0] m1_req_wdata,
  output logic        m1_resp_valid,
  output logic        m1_resp_err,
  output logic [63:0] m1_resp_rdata,

  output logic        tmr_cen_o,
  output logic        tmr_wen_o,
  output logic [63:0] tmr_addr_o,
  output logic [63:0] tmr_wdata_o,
  input  logic [63:0] tmr_rdata_i
);

  localparam int unsigned DW = 64;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_grant_q, last_grant_d;
  logic            wen_q, wen_d;
  logic [DW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            err_q, err_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic            gnt_valid;
  logic            gnt_id;
  logic            accept;
  logic            hit;

  // Full 64-bit decode of the latched address against the two timer registers.
  assign hit = (addr_q == ADDR_MTIME) || (addr_q == ADDR_MTIMECMP);

  // Round-robin pick: a lone requester wins; on contention the one not granted last wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (m0_req_valid && m1_req_valid) begin
      gnt_valid = 1'b1;
      gnt_id    = ~last_grant_q;
    end else if (m0_req_valid) begin
      gnt_valid = 1'b1;
      gnt_id    = 1'b0;
    end else if (m1_req_valid) begin
      gnt_valid = 1'b1;
      gnt_id    = 1'b1;
    end
  end

  // Ready is held low while reset is applied so nothing is advertised as accepted.
  assign accept = rst_n && (state_q == S_IDLE) && gnt_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> ACCESS on accept, then one cycle each of ACCESS and RESP.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath registers: request latch, arbitration history, response capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  // Datapath next values: latch the winner on accept, capture result during ACCESS.
  always_comb begin
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wen_d        = wen_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    if (accept) begin
      owner_d      = gnt_id;
      last_grant_d = gnt_id;
      wen_d        = gnt_id ? m1_req_wen   : m0_req_wen;
      addr_d       = gnt_id ? m1_req_addr  : m0_req_addr;
      wdata_d      = gnt_id ? m1_req_wdata : m0_req_wdata;
    end
    if (state_q == S_ACCESS) begin
      err_d   = ~hit;
      rdata_d = (hit && !wen_q) ? tmr_rdata_i : '0;
    end
  end

  // Output decode from registered state.
  always_comb begin
    m0_req_ready  = accept && (gnt_id == 1'b0);
    m1_req_ready  = accept && (gnt_id == 1'b1);

    tmr_addr_o    = addr_q;
    tmr_cen_o     = 1'b0;
    tmr_wen_o     = 1'b0;
    tmr_wdata_o   = '0;
    if (state_q == S_ACCESS) begin
      tmr_cen_o   = hit;
      tmr_wen_o   = hit && wen_q;
      tmr_wdata_o = wdata_q;
    end

    m0_resp_valid = (state_q == S_RESP) && (owner_q == 1'b0);
    m1_resp_valid = (state_q == S_RESP) && (owner_q == 1'b1);
    m0_resp_err   = m0_resp_valid && err_q;
    m1_resp_err   = m1_resp_valid && err_q;
    m0_resp_rdata = m0_resp_valid ? rdata_q : '0;
    m1_resp_rdata = m1_resp_valid ? rdata_q : '0;
  end

endmodule

// File: tb/tb_clint_arb.sv
// Scoreboard bench for clint_arb with a behavioural mtime/mtimecmp model.
module tb_clint_arb;

  localparam logic [63:0] A_MTIME = 64'h0000_0000_0200_BFF8;
  localparam logic [63:0] A_CMP   = 64'h0000_0000_0200_4000;
  localparam logic [63:0] A_BAD   = 64'h0000_0000_0200_0000;
  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk, rst_n;
  logic        m0_req_valid, m0_req_ready, m0_req_wen;
  logic [63:0] m0_req_addr, m0_req_wdata;
  logic        m0_resp_valid, m0_resp_err;
  logic [63:0] m0_resp_rdata;
  logic        m1_req_valid, m1_req_ready, m1_req_wen;
  logic [63:0] m1_req_addr, m1_req_wdata;
  logic        m1_resp_valid, m1_resp_err;
  logic [63:0] m1_resp_rdata;
  logic        tmr_cen_o, tmr_wen_o;
  logic [63:0] tmr_addr_o, tmr_wdata_o, tmr_rdata_i;

  typedef struct packed {
    logic        port;
    logic        err;
    logic [63:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [63:0] mtime, mtimecmp;
  logic        timer_int;

  clint_arb dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_wen(m0_req_wen),
    .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata),
    .m0_resp_valid(m0_resp_valid), .m0_resp_err(m0_resp_err), .m0_resp_rdata(m0_resp_rdata),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_wen(m1_req_wen),
    .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata),
    .m1_resp_valid(m1_resp_valid), .m1_resp_err(m1_resp_err), .m1_resp_rdata(m1_resp_rdata),
    .tmr_cen_o(tmr_cen_o), .tmr_wen_o(tmr_wen_o), .tmr_addr_o(tmr_addr_o),
    .tmr_wdata_o(tmr_wdata_o), .tmr_rdata_i(tmr_rdata_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Timer model: mtime counts every cycle unless written; mtimecmp resets to all ones.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      mtime    <= 64'd0;
      mtimecmp <= ONES;
    end else begin
      if (tmr_cen_o && tmr_wen_o && tmr_addr_o == A_MTIME) mtime <= tmr_wdata_o;
      else mtime <= mtime + 64'd1;
      if (tmr_cen_o && tmr_wen_o && tmr_addr_o == A_CMP) mtimecmp <= tmr_wdata_o;
    end
  end

  assign tmr_rdata_i = (tmr_addr_o == A_MTIME) ? mtime :
                       (tmr_addr_o == A_CMP)   ? mtimecmp : 64'd0;
  assign timer_int   = (mtime >= mtimecmp);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic set_req(input bit port, input bit v, input bit w,
                         input logic [63:0] a, input logic [63:0] d);
    if (port) begin
      m1_req_valid = v; m1_req_wen = w; m1_req_addr = a; m1_req_wdata = d;
    end else begin
      m0_req_valid = v; m0_req_wen = w; m0_req_addr = a; m0_req_wdata = d;
    end
  endtask

  // Called at a falling edge; returns 1 ns after the falling edge where ready is seen.
  task automatic wait_ready(input bit port, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (port ? m1_req_ready : m0_req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout port %0d: got no ready, expected ready within 20 cycles", port);
    end
  endtask

  // One complete transaction; returns 2 ns into the RESP cycle.
  task automatic xact(input bit port, input bit w, input logic [63:0] a, input logic [63:0] d,
                      input bit exp_cen, input bit exp_err, input logic [63:0] exp_rdata);
    bit   ok;
    exp_t e;
    set_req(port, 1'b1, w, a, d);
    wait_ready(port, ok);
    if (ok) begin
      e.port = port; e.err = exp_err; e.rdata = exp_rdata;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      set_req(port, 1'b0, 1'b0, 64'd0, 64'd0);
      check1("access_cen", tmr_cen_o, exp_cen);
      check1("access_wen", tmr_wen_o, exp_cen & w);
      check("access_addr", tmr_addr_o, a);
      check("access_wdata", tmr_wdata_o, d);
      @(negedge clk);
      #2;
      check("resp_pending", 64'(sb.size()), 64'd0);
    end else begin
      set_req(port, 1'b0, 1'b0, 64'd0, 64'd0);
    end
  endtask

  // Response monitor: every resp_valid pulse must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (m0_resp_valid && m1_resp_valid) begin
        checks++;
        errors++;
        $display("FAIL resp_both: got both resp_valid high, expected at most one");
      end
      if (m0_resp_valid || m1_resp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected: got resp on port %0d, expected none", m1_resp_valid);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check1("resp_port", m1_resp_valid, e.port);
          check1("resp_err", m1_resp_valid ? m1_resp_err : m0_resp_err, e.err);
          check("resp_rdata", m1_resp_valid ? m1_resp_rdata : m0_resp_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   ok;
    int   last_acc;
    exp_t e;
    rst_n = 1'b0;
    set_req(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
    set_req(1'b0, 1'b1, 1'b0, A_CMP, 64'd0);
    repeat (3) @(negedge clk);
    #1;
    check1("rst_m0_ready", m0_req_ready, 1'b0);
    check1("rst_m1_ready", m1_req_ready, 1'b0);
    check1("rst_m0_rvalid", m0_resp_valid, 1'b0);
    check1("rst_m1_rvalid", m1_resp_valid, 1'b0);
    check1("rst_m0_err", m0_resp_err, 1'b0);
    check("rst_m0_rdata", m0_resp_rdata, 64'd0);
    check("rst_m1_rdata", m1_resp_rdata, 64'd0);
    check1("rst_cen", tmr_cen_o, 1'b0);
    check1("rst_wen", tmr_wen_o, 1'b0);
    check("rst_addr", tmr_addr_o, 64'd0);
    check("rst_wdata", tmr_wdata_o, 64'd0);

    // Single read of mtimecmp right after reset.
    rst_n = 1'b1;
    #1;
    check1("post_rst_m0_ready", m0_req_ready, 1'b1);
    check1("post_rst_m1_ready", m1_req_ready, 1'b0);
    xact(1'b0, 1'b0, A_CMP, 64'd0, 1'b1, 1'b0, ONES);

    // Write mtime then read it back as soon as ready: write value + 2.
    xact(1'b1, 1'b1, A_MTIME, 64'h100, 1'b1, 1'b0, 64'd0);
    xact(1'b1, 1'b0, A_MTIME, 64'd0, 1'b1, 1'b0, 64'h102);

    // mtimecmp write raises the timer interrupt.
    check1("timer_int_before", timer_int, 1'b0);
    xact(1'b0, 1'b1, A_CMP, 64'h90, 1'b1, 1'b0, 64'd0);
    check1("timer_int_after", timer_int, 1'b1);
    xact(1'b1, 1'b0, A_CMP, 64'd0, 1'b1, 1'b0, 64'h90);

    // Unmapped address: no strobe, error response.
    xact(1'b0, 1'b0, A_BAD, 64'd0, 1'b0, 1'b1, 64'd0);

    // m1 valid raised during RESP and dropped before IDLE: nothing happens.
    xact(1'b0, 1'b0, A_CMP, 64'd0, 1'b1, 1'b0, 64'h90);
    set_req(1'b1, 1'b1, 1'b1, A_MTIME, 64'h777);
    #1;
    check1("drop_ready_resp", m1_req_ready, 1'b0);
    set_req(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
    repeat (3) begin
      @(negedge clk);
      #1;
      check1("drop_cen", tmr_cen_o, 1'b0);
      check1("drop_ready", m1_req_ready, 1'b0);
    end

    // Reset during ACCESS of an m1 write: the response is dropped.
    @(negedge clk);
    set_req(1'b1, 1'b1, 1'b1, A_MTIME, 64'h555);
    wait_ready(1'b1, ok);
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
      check1("midop_cen", tmr_cen_o, 1'b1);
    end
    rst_n = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, A_CMP, 64'd0);
    set_req(1'b1, 1'b1, 1'b0, A_BAD, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check1("midop_m0_first", m0_req_ready, 1'b1);
    check1("midop_m1_wait", m1_req_ready, 1'b0);

    // Continuous contention: grants alternate 0,1,0,1, three cycles apart.
    last_acc = 0;
    for (int k = 0; k < 4; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (m0_req_ready || m1_req_ready) begin
          ok = 1'b1;
          break;
        end
        @(negedge clk);
        #1;
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL contend_timeout %0d: got no grant, expected grant within 20 cycles", k);
        break;
      end
      check1("contend_m0_ready", m0_req_ready, (k % 2) == 0);
      check1("contend_m1_ready", m1_req_ready, (k % 2) == 1);
      if (k > 0) check("contend_spacing", 64'(cyc - last_acc), 64'd3);
      last_acc = cyc;
      e.port  = ((k % 2) == 1);
      e.err   = ((k % 2) == 1);
      e.rdata = ((k % 2) == 1) ? 64'd0 : ONES;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    set_req(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
    set_req(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    #2;
    check("contend_pending", 64'(sb.size()), 64'd0);

    repeat (4) @(negedge clk);
    check("final_pending", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
